// File: rtl/mem_access_stage_if.sv
// Signal bundle around the MEM stage: EX->MEM input, data-SRAM port,
// MEM->WB output and the MEM bypass bus.
interface mem_access_stage_if;
  logic         EX_to_MEM_valid;
  logic         MEM_allow_in;
  logic [112:0] EX_to_MEM_bus;

  logic         data_sram_req;
  logic         data_sram_wr;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  logic         MEM_to_WB_valid;
  logic         WB_allow_in;
  logic [110:0] MEM_to_WB_bus;
  logic [38:0]  MEM_to_BY_bus;

  modport master (
    input  EX_to_MEM_valid, EX_to_MEM_bus,
    output MEM_allow_in,
    output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_BY_bus,
    input  WB_allow_in
  );

  modport slave (
    output EX_to_MEM_valid, EX_to_MEM_bus,
    input  MEM_allow_in,
    input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_BY_bus,
    output WB_allow_in
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one data-SRAM request per load/store, holds the
// instruction until its response, then hands the bundle to WB.
module mem_access_stage (
  input  logic clk,
  input  logic reset,
  mem_access_stage_if.master io
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e       state_q, state_d;
  logic         mem_valid_q;
  logic [112:0] bus_q;
  logic [31:0]  rdata_buf_q;
  logic         ready_go, accept, req;

  logic [2:0]  f_stage;
  logic        f_rf_w_en, f_rf_w_data, f_sel_wd, f_en, f_we;
  logic [3:0]  f_b_en;
  logic [31:0] f_w_data, f_alu, f_pc, r_data;
  logic [4:0]  f_rd;
  logic        by_valid;

  assign {f_stage, f_rf_w_en, f_rf_w_data, f_sel_wd, f_en, f_we, f_b_en,
          f_w_data, f_rd, f_alu, f_pc} = bus_q;

  // ready_go kept outside the FSM process so allow_in/accept stay acyclic
  assign ready_go = (state_q == IDLE) || (state_q == HOLD) ||
                    ((state_q == WAIT) && io.data_sram_data_ok);
  assign io.MEM_allow_in    = ~mem_valid_q | (ready_go & io.WB_allow_in);
  assign io.MEM_to_WB_valid = mem_valid_q & ready_go;
  assign accept = io.EX_to_MEM_valid & io.MEM_allow_in;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: ;
      REQ: begin
        req = 1'b1;
        if (io.data_sram_addr_ok) state_d = WAIT;
      end
      WAIT:
        if (io.data_sram_data_ok) state_d = io.WB_allow_in ? IDLE : HOLD;
      HOLD:
        if (io.WB_allow_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a newly accepted bundle decides the next state regardless of origin
    if (accept) state_d = io.EX_to_MEM_bus[106] ? REQ : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      rdata_buf_q <= '0;
    end else begin
      state_q <= state_d;
      if (io.MEM_allow_in) mem_valid_q <= io.EX_to_MEM_valid;
      if (accept) bus_q <= io.EX_to_MEM_bus;
      if ((state_q == WAIT) && io.data_sram_data_ok && !io.WB_allow_in)
        rdata_buf_q <= io.data_sram_rdata;
    end
  end

  assign io.data_sram_req   = req;
  assign io.data_sram_wr    = f_we;
  assign io.data_sram_wstrb = f_we ? f_b_en : 4'b0;
  assign io.data_sram_addr  = f_alu;
  assign io.data_sram_wdata = (f_sel_wd & f_we) ? {4{f_w_data[7:0]}} : f_w_data;

  assign r_data = !f_en              ? 32'h0 :
                  (state_q == HOLD)  ? rdata_buf_q : io.data_sram_rdata;

  assign io.MEM_to_WB_bus = {f_stage, f_rf_w_en, f_rf_w_data, f_sel_wd, f_b_en,
                             r_data, f_rd, f_alu, f_pc};

  // loads are produced in WB, so only ALU-class results are forwarded here
  assign by_valid = mem_valid_q & ~f_rf_w_data & (f_stage[0] | f_stage[1]);
  assign io.MEM_to_BY_bus = {f_rd, f_alu, by_valid, f_rf_w_en};
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: reset, ALU pass-through, load, store,
// stalls with HOLD, reset mid-transaction and back-to-back loads.
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  mem_access_stage_if ifc();
  mem_access_stage dut (.clk(clk), .reset(reset), .io(ifc));

  always #5 clk = ~clk;

  function automatic logic [112:0] mk_ex(input logic [2:0] stg, input logic rfwen,
      input logic rfwd, input logic selwd, input logic en, input logic we,
      input logic [3:0] ben, input logic [31:0] wdat, input logic [4:0] rd,
      input logic [31:0] alu, input logic [31:0] pc);
    return {stg, rfwen, rfwd, selwd, en, we, ben, wdat, rd, alu, pc};
  endfunction

  function automatic logic [31:0] wb_rdata(input logic [110:0] b); return b[100:69]; endfunction
  function automatic logic [31:0] wb_alu(input logic [110:0] b);   return b[63:32];  endfunction
  function automatic logic [4:0]  wb_rd(input logic [110:0] b);    return b[68:64];  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.EX_to_MEM_valid   = 1'b0;
    ifc.EX_to_MEM_bus     = '0;
    ifc.data_sram_addr_ok = 1'b0;
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata   = '0;
    ifc.WB_allow_in       = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (ifc.MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", ifc.MEM_to_WB_valid); end
    total++; if (ifc.data_sram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", ifc.data_sram_req); end
    total++; if (ifc.MEM_allow_in !== 1'b1) begin bad++; $display("FAIL reset_allow_in got=%b exp=1", ifc.MEM_allow_in); end
    total++; if (ifc.MEM_to_WB_bus !== 111'h0) begin bad++; $display("FAIL reset_wb_bus got=%h exp=0", ifc.MEM_to_WB_bus); end
    total++; if (ifc.MEM_to_BY_bus !== 39'h0) begin bad++; $display("FAIL reset_by_bus got=%h exp=0", ifc.MEM_to_BY_bus); end
  endtask

  task automatic test_alu();
    ifc.EX_to_MEM_valid = 1'b1;
    ifc.EX_to_MEM_bus   = mk_ex(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,
                                5'd5, 32'h0000_1234, 32'h0000_0100);
    tick();
    ifc.EX_to_MEM_valid = 1'b0;
    #1;
    total++; if (ifc.MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid got=%b exp=1", ifc.MEM_to_WB_valid); end
    total++; if (wb_alu(ifc.MEM_to_WB_bus) !== 32'h1234) begin bad++; $display("FAIL alu_result got=%h exp=00001234", wb_alu(ifc.MEM_to_WB_bus)); end
    total++; if (wb_rd(ifc.MEM_to_WB_bus) !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d exp=5", wb_rd(ifc.MEM_to_WB_bus)); end
    total++; if (ifc.MEM_to_BY_bus !== {5'd5, 32'h1234, 1'b1, 1'b1}) begin bad++; $display("FAIL alu_bypass got=%h exp=%h", ifc.MEM_to_BY_bus, {5'd5, 32'h1234, 1'b1, 1'b1}); end
    total++; if (ifc.data_sram_req !== 1'b0) begin bad++; $display("FAIL alu_no_req got=%b exp=0", ifc.data_sram_req); end
    tick();
    total++; if (ifc.MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL alu_drained got=%b exp=0", ifc.MEM_to_WB_valid); end
  endtask

  task automatic test_load();
    ifc.EX_to_MEM_valid = 1'b1;
    ifc.EX_to_MEM_bus   = mk_ex(3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0,
                                5'd7, 32'h0000_1000, 32'h0000_0104);
    tick();
    ifc.EX_to_MEM_valid   = 1'b0;
    ifc.data_sram_addr_ok = 1'b1;
    #1;
    total++; if (ifc.data_sram_req !== 1'b1) begin bad++; $display("FAIL load_req got=%b exp=1", ifc.data_sram_req); end
    total++; if ({ifc.data_sram_addr, ifc.data_sram_wr, ifc.data_sram_wstrb} !== {32'h1000, 1'b0, 4'h0}) begin bad++; $display("FAIL load_req_fields got=%h/%b/%b exp=00001000/0/0000", ifc.data_sram_addr, ifc.data_sram_wr, ifc.data_sram_wstrb); end
    total++; if ({ifc.MEM_to_WB_valid, ifc.MEM_allow_in} !== 2'b00) begin bad++; $display("FAIL load_blocked got=%b exp=00", {ifc.MEM_to_WB_valid, ifc.MEM_allow_in}); end
    tick();
    ifc.data_sram_addr_ok = 1'b0;
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    total++; if (ifc.data_sram_req !== 1'b0) begin bad++; $display("FAIL load_req_once got=%b exp=0", ifc.data_sram_req); end
    total++; if (ifc.MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL load_wb_valid got=%b exp=1", ifc.MEM_to_WB_valid); end
    total++; if (wb_rdata(ifc.MEM_to_WB_bus) !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", wb_rdata(ifc.MEM_to_WB_bus)); end
    total++; if (ifc.MEM_to_BY_bus[1] !== 1'b0) begin bad++; $display("FAIL load_bypass_valid got=%b exp=0", ifc.MEM_to_BY_bus[1]); end
    tick();
    ifc.data_sram_data_ok = 1'b0;
    #1;
    total++; if ({ifc.MEM_to_WB_valid, ifc.data_sram_req} !== 2'b00) begin bad++; $display("FAIL load_drained got=%b exp=00", {ifc.MEM_to_WB_valid, ifc.data_sram_req}); end
  endtask

  task automatic test_store();
    ifc.EX_to_MEM_valid = 1'b1;
    ifc.EX_to_MEM_bus   = mk_ex(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100,
                                32'h0000_00A5, 5'd0, 32'h0000_1002, 32'h0000_0108);
    tick();
    ifc.EX_to_MEM_valid   = 1'b0;
    ifc.data_sram_addr_ok = 1'b1;
    #1;
    total++; if ({ifc.data_sram_req, ifc.data_sram_wr, ifc.data_sram_wstrb} !== {1'b1, 1'b1, 4'b0100}) begin bad++; $display("FAIL store_req_wr_wstrb got=%b exp=110100", {ifc.data_sram_req, ifc.data_sram_wr, ifc.data_sram_wstrb}); end
    total++; if (ifc.data_sram_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL store_wdata got=%h exp=a5a5a5a5", ifc.data_sram_wdata); end
    tick();
    ifc.data_sram_addr_ok = 1'b0;
    #1;
    total++; if ({ifc.MEM_allow_in, ifc.MEM_to_WB_valid} !== 2'b00) begin bad++; $display("FAIL store_wait_blocked got=%b exp=00", {ifc.MEM_allow_in, ifc.MEM_to_WB_valid}); end
    tick();
    ifc.data_sram_data_ok = 1'b1;
    #1;
    total++; if ({ifc.MEM_allow_in, ifc.MEM_to_WB_valid} !== 2'b11) begin bad++; $display("FAIL store_done got=%b exp=11", {ifc.MEM_allow_in, ifc.MEM_to_WB_valid}); end
    tick();
    ifc.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_hold();
    ifc.EX_to_MEM_valid = 1'b1;
    ifc.EX_to_MEM_bus   = mk_ex(3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h5555_0000,
                                5'd9, 32'h0000_3000, 32'h0000_010C);
    tick();
    ifc.EX_to_MEM_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({ifc.data_sram_req, ifc.data_sram_addr, ifc.data_sram_wdata} !== {1'b1, 32'h3000, 32'h5555_0000}) begin bad++; $display("FAIL hold_req_stable cyc=%0d got=%b/%h/%h", i, ifc.data_sram_req, ifc.data_sram_addr, ifc.data_sram_wdata); end
      tick();
    end
    ifc.data_sram_addr_ok = 1'b1;
    tick();
    ifc.data_sram_addr_ok = 1'b0;
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h1122_3344;
    ifc.WB_allow_in       = 1'b0;
    tick();
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata   = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({ifc.MEM_to_WB_valid, ifc.MEM_allow_in, wb_rdata(ifc.MEM_to_WB_bus)} !== {1'b1, 1'b0, 32'h1122_3344}) begin bad++; $display("FAIL hold_stable cyc=%0d got=%b%b/%h exp=10/11223344", i, ifc.MEM_to_WB_valid, ifc.MEM_allow_in, wb_rdata(ifc.MEM_to_WB_bus)); end
      if (i == 0) tick();
    end
    ifc.WB_allow_in = 1'b1;
    tick();
    total++; if (ifc.MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL hold_drained got=%b exp=0", ifc.MEM_to_WB_valid); end
  endtask

  task automatic test_reset_wait();
    ifc.EX_to_MEM_valid = 1'b1;
    ifc.EX_to_MEM_bus   = mk_ex(3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0,
                                5'd3, 32'h0000_4000, 32'h0000_0110);
    tick();
    ifc.EX_to_MEM_valid   = 1'b0;
    ifc.data_sram_addr_ok = 1'b1;
    tick();
    ifc.data_sram_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if ({ifc.data_sram_req, ifc.MEM_to_WB_valid, ifc.MEM_allow_in} !== 3'b001) begin bad++; $display("FAIL rstwait_state got=%b exp=001", {ifc.data_sram_req, ifc.MEM_to_WB_valid, ifc.MEM_allow_in}); end
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'hBAD0_BAD0;
    #1;
    total++; if (ifc.MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL rstwait_late_dataok got=%b exp=0", ifc.MEM_to_WB_valid); end
    tick();
    ifc.data_sram_data_ok = 1'b0;
    #1;
    total++; if ({ifc.data_sram_req, ifc.MEM_to_WB_valid} !== 2'b00) begin bad++; $display("FAIL rstwait_after got=%b exp=00", {ifc.data_sram_req, ifc.MEM_to_WB_valid}); end
  endtask

  task automatic test_back_to_back();
    ifc.EX_to_MEM_valid = 1'b1;
    ifc.EX_to_MEM_bus   = mk_ex(3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0,
                                5'd1, 32'h0000_2000, 32'h0000_0200);
    tick();
    ifc.EX_to_MEM_bus     = mk_ex(3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0,
                                  5'd2, 32'h0000_2004, 32'h0000_0204);
    ifc.data_sram_addr_ok = 1'b1;
    #1;
    total++; if ({ifc.data_sram_req, ifc.data_sram_addr, ifc.MEM_allow_in} !== {1'b1, 32'h2000, 1'b0}) begin bad++; $display("FAIL b2b_req1 got=%b/%h/%b", ifc.data_sram_req, ifc.data_sram_addr, ifc.MEM_allow_in); end
    tick();
    ifc.data_sram_addr_ok = 1'b0;
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'hAAAA_0001;
    #1;
    total++; if ({ifc.MEM_to_WB_valid, ifc.data_sram_req, wb_alu(ifc.MEM_to_WB_bus), wb_rdata(ifc.MEM_to_WB_bus)} !== {1'b1, 1'b0, 32'h2000, 32'hAAAA_0001}) begin bad++; $display("FAIL b2b_result1 got=%b%b/%h/%h", ifc.MEM_to_WB_valid, ifc.data_sram_req, wb_alu(ifc.MEM_to_WB_bus), wb_rdata(ifc.MEM_to_WB_bus)); end
    tick();
    ifc.EX_to_MEM_valid   = 1'b0;
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_addr_ok = 1'b1;
    #1;
    total++; if ({ifc.data_sram_req, ifc.data_sram_addr, ifc.MEM_to_WB_valid} !== {1'b1, 32'h2004, 1'b0}) begin bad++; $display("FAIL b2b_req2 got=%b/%h/%b", ifc.data_sram_req, ifc.data_sram_addr, ifc.MEM_to_WB_valid); end
    tick();
    ifc.data_sram_addr_ok = 1'b0;
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'hAAAA_0002;
    #1;
    total++; if ({ifc.MEM_to_WB_valid, ifc.data_sram_req, wb_alu(ifc.MEM_to_WB_bus), wb_rdata(ifc.MEM_to_WB_bus)} !== {1'b1, 1'b0, 32'h2004, 32'hAAAA_0002}) begin bad++; $display("FAIL b2b_result2 got=%b%b/%h/%h", ifc.MEM_to_WB_valid, ifc.data_sram_req, wb_alu(ifc.MEM_to_WB_bus), wb_rdata(ifc.MEM_to_WB_bus)); end
    tick();
    ifc.data_sram_data_ok = 1'b0;
    #1;
    total++; if ({ifc.MEM_to_WB_valid, ifc.data_sram_req} !== 2'b00) begin bad++; $display("FAIL b2b_drained got=%b exp=00", {ifc.MEM_to_WB_valid, ifc.data_sram_req}); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_hold();
    test_reset_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
